// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-level sequencer.
//   state_e  : FSM state encoding (also driven onto the debug LED port).
//   SCORE_W  : width of the score / high-score / rounds registers.
//   SCORE_MAX: score saturation value, so the score fits 4 BCD digits.
//   EV_*     : bit positions inside the event vector.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned SCORE_MAX = 9999;

  localparam int EV_ROBOT     = 0;
  localparam int EV_DRAGON_LO = 1;
  localparam int EV_DRAGON_HI = 3;

endpackage

// File: rtl/game_flow_ctrl_score_acc.sv
// score_acc: combinational score accumulator.
//   score_i   : current score
//   h_score_i : current high score
//   kills_i   : dragon-killed flags for this tick (one bit per dragon)
//   score_o   : score plus number of kills, saturated at SCORE_MAX
//   h_score_o : max(h_score_i, score_o)
module score_acc #(
  parameter int unsigned SCORE_MAX = game_pkg::SCORE_MAX
) (
  input  logic [game_pkg::SCORE_W-1:0] score_i,
  input  logic [game_pkg::SCORE_W-1:0] h_score_i,
  input  logic [2:0]                   kills_i,
  output logic [game_pkg::SCORE_W-1:0] score_o,
  output logic [game_pkg::SCORE_W-1:0] h_score_o
);
  import game_pkg::*;

  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(SCORE_MAX);

  logic [1:0]       inc;
  logic [SCORE_W:0] sum;

  always_comb begin
    inc = {1'b0, kills_i[0]} + {1'b0, kills_i[1]} + {1'b0, kills_i[2]};
    // One extra bit so the compare sees any overshoot before clipping.
    sum = {1'b0, score_i} + {{(SCORE_W-1){1'b0}}, inc};
    score_o   = (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
    h_score_o = (score_o > h_score_i) ? score_o : h_score_i;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-level sequencer on the slow game tick.
//   clk_i      : game tick, rising edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : one-tick start request
//   pause_i    : pause level
//   event_i    : [3:1] dragon-killed pulses, [0] robot-killed pulse
//   run_o      : movers may advance this tick (combinational)
//   respawn_o  : one-tick pulse, movers reload start positions
//   score_o, h_score_o, rounds_o, lives_o : game registers for display
//   state_o    : FSM state for debug LEDs
module game_flow_ctrl #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned RESPAWN_TICKS = 8,
  parameter int unsigned OVER_TICKS    = 48,
  parameter int unsigned SCORE_MAX     = game_pkg::SCORE_MAX
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         pause_i,
  input  logic [3:0]                   event_i,
  output logic                         run_o,
  output logic                         respawn_o,
  output logic [game_pkg::SCORE_W-1:0] score_o,
  output logic [game_pkg::SCORE_W-1:0] h_score_o,
  output logic [game_pkg::SCORE_W-1:0] rounds_o,
  output logic [1:0]                   lives_o,
  output logic [2:0]                   state_o
);
  import game_pkg::*;

  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] RESPAWN_LOAD = TMR_W'(RESPAWN_TICKS);
  localparam logic [TMR_W-1:0] OVER_LOAD    = TMR_W'(OVER_TICKS);
  localparam logic [1:0]       LIVES_INIT   = 2'(LIVES);

  state_e             state_q;
  logic               resume_rsp_q;  // 1: PAUSE returns to RESPAWN, 0: to PLAY
  logic [TMR_W-1:0]   timer_q;
  logic               respawn_q;
  logic [SCORE_W-1:0] score_q, h_score_q, rounds_q;
  logic [1:0]         lives_q;
  logic [SCORE_W-1:0] score_d, h_score_d;

  score_acc #(.SCORE_MAX(SCORE_MAX)) u_score_acc (
    .score_i   (score_q),
    .h_score_i (h_score_q),
    .kills_i   (event_i[EV_DRAGON_HI:EV_DRAGON_LO]),
    .score_o   (score_d),
    .h_score_o (h_score_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      resume_rsp_q <= 1'b0;
      timer_q      <= '0;
      respawn_q    <= 1'b0;
      score_q      <= '0;
      h_score_q    <= '0;
      rounds_q     <= '0;
      lives_q      <= '0;
    end else begin
      respawn_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_PLAY;
            score_q   <= '0;
            rounds_q  <= SCORE_W'(1);
            lives_q   <= LIVES_INIT;
            respawn_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          // Pause wins over events arriving in the same tick.
          if (pause_i) begin
            resume_rsp_q <= 1'b0;
            state_q      <= ST_PAUSE;
          end else begin
            score_q   <= score_d;
            h_score_q <= h_score_d;
            if (event_i[EV_ROBOT]) begin
              if (lives_q == 2'd1) begin
                lives_q <= 2'd0;
                timer_q <= OVER_LOAD;
                state_q <= ST_OVER;
              end else begin
                lives_q <= lives_q - 2'd1;
                if (rounds_q != '1) rounds_q <= rounds_q + SCORE_W'(1);
                timer_q <= RESPAWN_LOAD;
                state_q <= ST_RESPAWN;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!pause_i) state_q <= resume_rsp_q ? ST_RESPAWN : ST_PLAY;
        end
        ST_RESPAWN: begin
          if (pause_i) begin
            resume_rsp_q <= 1'b1;
            state_q      <= ST_PAUSE;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
            if (timer_q == TMR_W'(1)) begin
              respawn_q <= 1'b1;
              state_q   <= ST_PLAY;
            end
          end
        end
        ST_OVER: begin
          timer_q <= timer_q - TMR_W'(1);
          if (timer_q == TMR_W'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational so a pause freezes the movers in the same tick.
  assign run_o     = (state_q == ST_PLAY) & ~pause_i;
  assign respawn_o = respawn_q;
  assign score_o   = score_q;
  assign h_score_o = h_score_q;
  assign rounds_o  = rounds_q;
  assign lives_o   = lives_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_RESPAWN = 3, M_OVER = 4;
  localparam int LIVES_P = 3, RESP_P = 8, OVER_P = 48, SMAX = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  ev_in = 4'b0;
  logic        run, respawn;
  logic [13:0] score, h_score, rounds;
  logic [1:0]  lives;
  logic [2:0]  state;

  game_flow_ctrl #(.LIVES(3), .RESPAWN_TICKS(8), .OVER_TICKS(48), .SCORE_MAX(9999)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .event_i(ev_in),
    .run_o(run), .respawn_o(respawn), .score_o(score), .h_score_o(h_score),
    .rounds_o(rounds), .lives_o(lives), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game status as plain integers.
  int  m_mode, m_score, m_hs, m_rounds, m_lives, m_left, m_resp, m_back;
  logic last_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_hs = 0; m_rounds = 0; m_lives = 0;
    m_left = 0; m_resp = 0; m_back = M_PLAY;
  endtask

  task automatic model_step(input logic st, input logic pz, input logic [3:0] ev);
    m_resp = 0;
    if (m_mode == M_IDLE) begin
      if (st) begin
        m_mode = M_PLAY; m_score = 0; m_rounds = 1; m_lives = LIVES_P; m_resp = 1;
      end
    end else if (m_mode == M_PLAY) begin
      if (pz) begin
        m_back = M_PLAY; m_mode = M_PAUSE;
      end else begin
        m_score = m_score + $countones(ev[3:1]);
        if (m_score > SMAX) m_score = SMAX;
        if (m_score > m_hs) m_hs = m_score;
        if (ev[0]) begin
          if (m_lives == 1) begin
            m_lives = 0; m_mode = M_OVER; m_left = OVER_P;
          end else begin
            m_lives--; m_rounds = (m_rounds >= 16383) ? 16383 : m_rounds + 1;
            m_mode = M_RESPAWN; m_left = RESP_P;
          end
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (!pz) m_mode = m_back;
    end else if (m_mode == M_RESPAWN) begin
      if (pz) begin
        m_back = M_RESPAWN; m_mode = M_PAUSE;
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = M_PLAY; m_resp = 1; end
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = M_IDLE;
    end
  endtask

  task automatic check_model();
    check("state", state, m_mode);
    check("lives", lives, m_lives);
    check("score", score, m_score);
    check("h_score", h_score, m_hs);
    check("rounds", rounds, m_rounds);
    check("respawn", respawn, m_resp);
  endtask

  task automatic tick(input logic st, input logic pz, input logic [3:0] ev);
    @(negedge clk);
    start = st; pause = pz; ev_in = ev;
    #1;
    last_run = run;
    check("run", run, (m_mode == M_PLAY) && !pz);
    @(posedge clk);
    model_step(st, pz, ev);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 0; pause = 0; ev_in = 0;
    #1;
    check("rst_state", state, 0);
    check("rst_respawn", respawn, 0);
    check("rst_score", score, 0);
    check("rst_h_score", h_score, 0);
    check("rst_rounds", rounds, 0);
    check("rst_lives", lives, 0);
    check("rst_run", run, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        st;
    logic        pz;
    logic [3:0]  ev;
    logic        run;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [13:0] score;
    logic [13:0] rounds;
    logic        resp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd1, 2'd3, 14'd0, 14'd1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 3'd1, 2'd3, 14'd0, 14'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b1110, 1'b1, 3'd1, 2'd3, 14'd3, 14'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0011, 1'b1, 3'd3, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd3, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 3'd3, 2'd2, 14'd4, 14'd2, 1'b0};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd3, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 2'd2, 14'd4, 14'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 3'd1, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'b0001, 1'b0, 3'd2, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 2'd2, 14'd4, 14'd2, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 2'd2, 14'd4, 14'd2, 1'b0};

    model_reset();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].st, tbl[i].pz, tbl[i].ev);
      check($sformatf("vec%0d_run", i), last_run, tbl[i].run);
      check($sformatf("vec%0d_state", i), state, tbl[i].state);
      check($sformatf("vec%0d_lives", i), lives, tbl[i].lives);
      check($sformatf("vec%0d_score", i), score, tbl[i].score);
      check($sformatf("vec%0d_rounds", i), rounds, tbl[i].rounds);
      check($sformatf("vec%0d_respawn", i), respawn, tbl[i].resp);
    end

    // Pause in the middle of a respawn freeze with 5 ticks left.
    begin
      int  cnt;
      bit  seen;
      tick(0, 0, 4'b0001);
      repeat (3) tick(0, 0, 4'b0000);
      repeat (10) tick(0, 1, 4'b0001);
      check("pause_in_respawn_state", state, 2);
      tick(0, 0, 4'b0000);
      check("resume_to_respawn", state, 3);
      cnt = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick(0, 0, 4'b0000);
        cnt++;
        if (respawn === 1'b1) seen = 1;
      end
      check("respawn_ticks_after_pause", cnt, 5);
      check("back_in_play", state, 1);
    end

    // Score saturation: 4 + 3*3331 + 1 = 9998, then kills clip at 9999.
    for (int i = 0; i < 3331; i++) tick(0, 0, 4'b1110);
    tick(0, 0, 4'b0010);
    check("score_9998", score, 9998);
    tick(0, 0, 4'b1110);
    check("score_sat", score, 9999);
    check("h_score_sat", h_score, 9999);
    tick(0, 0, 4'b0100);
    check("score_hold_sat", score, 9999);

    // Last life lost -> OVER, start ignored for the hold time.
    tick(0, 0, 4'b0001);
    check("over_state", state, 4);
    check("over_lives", lives, 0);
    for (int i = 0; i < 48; i++) begin
      tick(1, logic'($urandom_range(0, 1)), 4'b0000);
      check($sformatf("over_hold%0d", i), state, (i < 47) ? 4 : 0);
    end
    check("idle_keeps_h_score", h_score, 9999);
    check("idle_keeps_score", score, 9999);
    tick(1, 0, 4'b0000);
    check("restart_score", score, 0);
    check("restart_h_score", h_score, 9999);

    // Randomized play against the model.
    for (int i = 0; i < 1500; i++) begin
      logic       st, pz;
      logic [3:0] ev;
      st = ($urandom_range(0, 15) == 0);
      pz = ($urandom_range(0, 6) == 0);
      ev = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) ev[0] = 1'b0;
      tick(st, pz, ev);
    end

    // Mid-game reset while a respawn freeze is running.
    tick(1, 0, 4'b0000);
    tick(1, 0, 4'b0000);
    tick(0, 0, 4'b0001);
    tick(0, 0, 4'b0000);
    do_reset();
    tick(0, 0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-level sequencer. It sits between the per-object movers (dragon, robot and missile) and the score and seven-segment path. It decides when objects may move, based on start, pause, robot death and respawn. It owns the score, high-score, rounds and lives registers that feed the BCD converters. All logic runs on the slow game tick, so every object sees the same run/freeze decision in the same tick.

## Interface
Parameters:
- LIVES, 3: lives granted at game start (1..3).
- RESPAWN_TICKS, 8: freeze length after robot death, in clk ticks.
- OVER_TICKS, 48: game-over hold time before returning to IDLE.
- SCORE_MAX, 9999: saturation value, so the score fits 4 BCD digits.

Ports:
- clk  in  1  game tick (clk_22 domain); one clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start request, one-tick pulse (debounced pb).
- pause  in  1  pause level (dip switch).
- event  in  4  [3:1] dragon-killed pulses; [0] robot-killed pulse.
- run  out  1  movers may advance this tick.
- respawn  out  1  one-tick pulse; movers reload their start positions.
- score  out  14  current score.
- h_score  out  14  highest score since reset.
- rounds  out  14  current round number.
- lives  out  2  lives remaining.
- state  out  3  FSM state, for debug LEDs.

## Operation
- States: IDLE, PLAY, PAUSE, RESPAWN, OVER.
- IDLE:
  - run=0.
  - start → PLAY. In the same edge: score=0, rounds=1, lives=LIVES, respawn=1.
- PLAY:
  - run=!pause.
  - pause=1 → PAUSE. It is sampled before events, so events in that tick are ignored.
  - Otherwise, kills are scored first: inc = popcount(event[3:1]) (0..3); score = min(score+inc, SCORE_MAX).
  - h_score = max(h_score, new score) in the same edge.
  - If event[0]=1 in the same tick:
    - lives==1 → lives=0, go to OVER (timer=OVER_TICKS).
    - otherwise lives-1, rounds+1 (saturating at 16383), go to RESPAWN (timer=RESPAWN_TICKS).
- PAUSE:
  - run=0, all events ignored.
  - pause=0 → return to the state held before the pause (PLAY or RESPAWN). A 1-bit resume register holds that return state.
- RESPAWN:
  - run=0, events ignored.
  - pause=1 → PAUSE; the timer holds its value.
  - Timer decrements each tick. When timer==1: respawn=1, go to PLAY.
- OVER:
  - run=0, start ignored, score held for display.
  - Timer decrements each tick, pause does not stop it. When timer==1 → IDLE.
- IDLE retains score, rounds and h_score. Only rst clears h_score.
- start while in PLAY, PAUSE or RESPAWN: ignored.

## Timing
- Reset values: state=IDLE, run=0, respawn=0, score=0, h_score=0, rounds=0, lives=0, timer=0.
- All outputs are registered except run. run = (state==PLAY) & ~pause, decoded combinationally, so pausing takes effect in the same tick.
- Latency:
  - event → score/h_score update: 1 clk edge.
  - robot death → run low: next tick.
- Respawn freeze:
  - run is low for exactly RESPAWN_TICKS ticks when no pause occurs.
  - respawn pulses on the edge entering PLAY, and run is high in the following tick.
- Simultaneous kills and death in one tick: both are applied; score counts before the lives check.
- Saturation:
  - score stops at SCORE_MAX and never wraps.
  - rounds saturates at 14'h3FFF.
- Reset mid-game: asynchronous return to the reset values. Any pending respawn pulse is dropped.

## Structure
- Package game_pkg:
  - state enum (IDLE=0, PLAY=1, PAUSE=2, RESPAWN=3, OVER=4).
  - SCORE_MAX, SCORE_W=14.
  - the event bit index constants EV_ROBOT=0, EV_DRAGON_LO=1, EV_DRAGON_HI=3.
- Sub-module score_acc (combinational): 3-bit popcount, saturating add to SCORE_MAX, and high-score compare. Instantiated once.
- The FSM, timer, lives and rounds registers live in game_flow_ctrl.

## Test plan
- rst low, then start pulse → state=PLAY, lives=3, rounds=1, score=0, respawn high for 1 tick, run=1.
- PLAY, event=4'b1110 → score +3. Then event=4'b0011 → score +1 and RESPAWN: lives=2, rounds=2, run=0 for exactly 8 ticks, respawn pulse, back in PLAY.
- score preset to 9998, event=4'b1110 → score=9999 and h_score=9999. A further kill keeps 9999.
- RESPAWN with timer=5, pause held 10 ticks → state=PAUSE, timer frozen at 5. Release → RESPAWN, 5 more ticks, then PLAY.
- Third robot death → OVER, lives=0, start ignored for 48 ticks, then IDLE with h_score kept. New start → score=0, h_score unchanged.
- pause=1 in the same tick as event=4'b0001 → state=PAUSE, lives unchanged, run=0 immediately.
